lcd_controller: RTL

//  Queued HD44780 write engine for the character LCD. It sits between the CPU-side port

---
 rtl/lcd_controller_if.sv | 14 +
 rtl/lcd_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller_if.sv
// Host-side write port of the HD44780 write engine: queued {rs,byte} pushes plus status flags.
// The CPU side is the master; the engine is the slave.
interface lcd_controller_if;
  logic       wr_en;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic       busy;
  logic       init_done;

  modport master (output wr_en, wr_rs, wr_data, input full, overflow, busy, init_done);
  modport slave  (input wr_en, wr_rs, wr_data, output full, overflow, busy, init_done);
endinterface

// File: rtl/lcd_controller.sv
// Queued HD44780 write engine: FIFO'd {rs,byte} writes, EN setup/pulse/hold timing, exec waits, power-on init.
// Latency: push -> pop next cycle -> SETUP the cycle after; pushes while full are dropped and flagged sticky.
module lcd_fifo #(
  parameter int W  = 9,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;

  assign push    = in_vld && !full;
  assign pop     = out_rdy && !empty;
  assign empty   = (count == '0);
  assign out_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop && !push)
      count_nxt = count - (AW+1)'(1);
  end

  // full is registered from the next occupancy so it is valid at the start of each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

module lcd_controller #(
  parameter int FIFO_AW        = 2,
  parameter int SETUP_CYCLES   = 3,
  parameter int PULSE_CYCLES   = 25,
  parameter int HOLD_CYCLES    = 3,
  parameter int EXEC_CYCLES    = 2500,
  parameter int CLEAR_CYCLES   = 100000,
  parameter int POWERUP_CYCLES = 2500000,
  parameter int INIT_ENABLE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  lcd_controller_if.slave   host,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en
);
  localparam bit INIT_ON = (INIT_ENABLE != 0);
  localparam int M0   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int M1   = (M0 > HOLD_CYCLES) ? M0 : HOLD_CYCLES;
  localparam int M2   = (M1 > EXEC_CYCLES) ? M1 : EXEC_CYCLES;
  localparam int M3   = (M2 > CLEAR_CYCLES) ? M2 : CLEAR_CYCLES;
  localparam int MAXC = (M3 > POWERUP_CYCLES) ? M3 : POWERUP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_POWERUP, ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_EXEC
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic          init_done;
  logic          overflow;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [8:0]    fifo_dat;
  logic          is_clear;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  lcd_fifo #(.W(9), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (host.wr_en),
    .in_dat  ({host.wr_rs, host.wr_data}),
    .out_rdy (fifo_pop),
    .out_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop       = (state == ST_IDLE) && init_done && !fifo_empty;
  assign is_clear       = !lcd_rs && (lcd_data inside {[8'h01:8'h03]});
  assign host.full      = fifo_full;
  assign host.overflow  = overflow;
  assign host.init_done = init_done;
  assign host.busy      = (state != ST_IDLE) || !fifo_empty;
  assign lcd_rw         = 1'b0;

  // Timed states load cnt with N-1 on entry and leave when it reaches zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_ON ? ST_POWERUP : ST_IDLE;
      cnt       <= CW'(POWERUP_CYCLES - 1);
      init_idx  <= 2'd0;
      init_done <= !INIT_ON;
      overflow  <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      if (host.wr_en && fifo_full)
        overflow <= 1'b1;
      case (state)
        ST_POWERUP: begin
          if (cnt == '0) begin
            state    <= ST_SETUP;
            cnt      <= CW'(SETUP_CYCLES - 1);
            init_idx <= 2'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(2'd0);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_IDLE: begin
          if (fifo_pop) begin
            state    <= ST_SETUP;
            cnt      <= CW'(SETUP_CYCLES - 1);
            lcd_rs   <= fifo_dat[8];
            lcd_data <= fifo_dat[7:0];
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state  <= ST_PULSE;
            cnt    <= CW'(PULSE_CYCLES - 1);
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            state  <= ST_HOLD;
            cnt    <= CW'(HOLD_CYCLES - 1);
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_EXEC;
            cnt   <= is_clear ? CW'(CLEAR_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!init_done && init_idx != 2'd3) begin
            state    <= ST_SETUP;
            cnt      <= CW'(SETUP_CYCLES - 1);
            init_idx <= init_idx + 2'd1;
            lcd_rs   <= 1'b0;
            lcd_data <= init_byte(init_idx + 2'd1);
          end else begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
